// File: rtl/block_scheduler.sv
// Row-major block-grid job dispatcher: walks every (i, j) block of a mu x mu
// grid, hands each to the lowest free compute unit and counts results back.
module block_scheduler #(
  parameter int N_CU        = 4,
  parameter int index_width = 8,
  parameter int max_mu_log  = 8
) (
  input  logic                          i_Clock,
  input  logic                          i_Reset,
  input  logic                          i_Start,
  input  logic [max_mu_log-1:0]         i_mu,
  output logic [max_mu_log-1:0]         o_mu,
  output logic [N_CU-1:0]               o_Indexes_Ready,
  output logic [N_CU*index_width-1:0]   o_Row_Index,
  output logic [N_CU*index_width-1:0]   o_Column_Index,
  input  logic [N_CU-1:0]               i_Indexes_Received,
  input  logic [N_CU-1:0]               i_Result_Ready,
  output logic                          o_Busy,
  output logic                          o_Done,
  output logic [2*max_mu_log-1:0]       o_Jobs_Completed
);

  localparam int TW = 2 * max_mu_log;
  localparam int CW = (index_width > max_mu_log) ? index_width : max_mu_log;

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_DRAIN = 2'd2, S_DONE = 2'd3} state_t;
  typedef enum logic [1:0] {SLOT_FREE = 2'd0, SLOT_OFFERED = 2'd1, SLOT_BUSY = 2'd2} slot_t;

  state_t                      state_r, state_s;
  slot_t                       slot_r [N_CU];
  logic [max_mu_log-1:0]       mu_r;
  logic [TW-1:0]               total_r, issued_r, jobs_r, finish_cnt_s;
  logic [index_width-1:0]      row_r, col_r;
  logic [N_CU-1:0]             ready_r, grant_s, free_s, finish_s;
  logic [N_CU*index_width-1:0] row_bus_r, col_bus_r;
  logic                        busy_r, done_r, all_free_s, offer_s, col_wrap_s, found_s, start_s;

  assign o_mu             = mu_r;
  assign o_Indexes_Ready  = ready_r;
  assign o_Row_Index      = row_bus_r;
  assign o_Column_Index   = col_bus_r;
  assign o_Busy           = busy_r;
  assign o_Done           = done_r;
  assign o_Jobs_Completed = jobs_r;

  assign start_s    = (state_r == S_IDLE) && i_Start;
  assign col_wrap_s = (CW'(col_r) == CW'(mu_r - max_mu_log'(1)));

  // Slot status decode and per-edge completion count
  always_comb begin
    free_s       = {N_CU{1'b0}};
    finish_s     = {N_CU{1'b0}};
    finish_cnt_s = {TW{1'b0}};
    for (int n = 0; n < N_CU; n++) begin
      free_s[n]    = (slot_r[n] == SLOT_FREE);
      finish_s[n]  = (slot_r[n] == SLOT_BUSY) && i_Result_Ready[n];
      finish_cnt_s = finish_cnt_s + TW'(finish_s[n]);
    end
    all_free_s = &free_s;
  end

  // Lowest-numbered free slot wins the single offer of this edge
  always_comb begin
    grant_s = {N_CU{1'b0}};
    found_s = 1'b0;
    offer_s = (state_r == S_RUN) && (issued_r != total_r) && (|free_s);
    for (int n = 0; n < N_CU; n++) begin
      grant_s[n] = offer_s && free_s[n] && !found_s;
      found_s    = found_s || free_s[n];
    end
  end

  // Top FSM next-state
  always_comb begin
    state_s = state_r;
    case (state_r)
      S_IDLE:  if (i_Start) state_s = S_RUN; else state_s = S_IDLE;
      S_RUN:   if (issued_r == total_r) state_s = S_DRAIN; else state_s = S_RUN;
      S_DRAIN: if (all_free_s) state_s = S_DONE; else state_s = S_DRAIN;
      S_DONE:  state_s = S_IDLE;
      default: state_s = S_IDLE;
    endcase
  end

  // Top FSM state register
  always_ff @(posedge i_Clock or negedge i_Reset) begin
    if (!i_Reset) state_r <= S_IDLE;
    else          state_r <= state_s;
  end

  // Run bookkeeping: latched mu, index walk, issue and completion counters
  always_ff @(posedge i_Clock or negedge i_Reset) begin
    if (!i_Reset) begin
      mu_r     <= {max_mu_log{1'b0}};
      total_r  <= {TW{1'b0}};
      issued_r <= {TW{1'b0}};
      jobs_r   <= {TW{1'b0}};
      row_r    <= {index_width{1'b0}};
      col_r    <= {index_width{1'b0}};
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
    end else begin
      busy_r <= (state_s == S_RUN) || (state_s == S_DRAIN);
      done_r <= (state_s == S_DONE);
      if (start_s) begin
        mu_r     <= i_mu;
        total_r  <= TW'(i_mu) * TW'(i_mu);
        issued_r <= {TW{1'b0}};
        jobs_r   <= {TW{1'b0}};
        row_r    <= {index_width{1'b0}};
        col_r    <= {index_width{1'b0}};
      end else begin
        jobs_r <= jobs_r + finish_cnt_s;
        if (offer_s) begin
          issued_r <= issued_r + TW'(1);
          if (col_wrap_s) begin
            col_r <= {index_width{1'b0}};
            row_r <= row_r + index_width'(1);
          end else begin
            col_r <= col_r + index_width'(1);
          end
        end
      end
    end
  end

  // Per-CU slot state; index buses hold until the next offer to that slot
  always_ff @(posedge i_Clock or negedge i_Reset) begin
    if (!i_Reset) begin
      for (int n = 0; n < N_CU; n++) slot_r[n] <= SLOT_FREE;
      ready_r   <= {N_CU{1'b0}};
      row_bus_r <= {(N_CU*index_width){1'b0}};
      col_bus_r <= {(N_CU*index_width){1'b0}};
    end else begin
      for (int n = 0; n < N_CU; n++) begin
        case (slot_r[n])
          SLOT_FREE: begin
            if (grant_s[n]) begin
              slot_r[n]                             <= SLOT_OFFERED;
              ready_r[n]                            <= 1'b1;
              row_bus_r[n*index_width +: index_width] <= row_r;
              col_bus_r[n*index_width +: index_width] <= col_r;
            end
          end
          SLOT_OFFERED: begin
            if (i_Indexes_Received[n]) begin
              slot_r[n]  <= SLOT_BUSY;
              ready_r[n] <= 1'b0;
            end
          end
          SLOT_BUSY: begin
            if (i_Result_Ready[n]) slot_r[n] <= SLOT_FREE;
          end
          default: begin
            slot_r[n]  <= SLOT_FREE;
            ready_r[n] <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_block_scheduler.sv
// Directed bench for block_scheduler: behavioural CU array, scoreboard of
// expected (row, col) offers in row-major order, and a slot-tracking monitor.
module tb_block_scheduler;
  localparam int NCU = 4;
  localparam int IW  = 8;
  localparam int MW  = 8;

  logic              i_Clock = 1'b0;
  logic              i_Reset = 1'b0;
  logic              i_Start = 1'b0;
  logic [MW-1:0]     i_mu    = 8'd0;
  logic [MW-1:0]     o_mu;
  logic [NCU-1:0]    o_Indexes_Ready;
  logic [NCU*IW-1:0] o_Row_Index, o_Column_Index;
  logic [NCU-1:0]    cu_ack   = 4'b0000;
  logic [NCU-1:0]    spur_ack = 4'b0000;
  logic [NCU-1:0]    cu_res   = 4'b1111;
  logic [NCU-1:0]    ack_s;
  logic              o_Busy, o_Done;
  logic [2*MW-1:0]   o_Jobs_Completed;

  assign ack_s = cu_ack | spur_ack;

  block_scheduler #(.N_CU(NCU), .index_width(IW), .max_mu_log(MW)) dut (
    .i_Clock(i_Clock), .i_Reset(i_Reset), .i_Start(i_Start), .i_mu(i_mu),
    .o_mu(o_mu), .o_Indexes_Ready(o_Indexes_Ready),
    .o_Row_Index(o_Row_Index), .o_Column_Index(o_Column_Index),
    .i_Indexes_Received(ack_s), .i_Result_Ready(cu_res),
    .o_Busy(o_Busy), .o_Done(o_Done), .o_Jobs_Completed(o_Jobs_Completed)
  );

  always #5 i_Clock = ~i_Clock;

  typedef struct {
    logic [IW-1:0] r;
    logic [IW-1:0] c;
  } job_t;
  job_t sb_q[$];

  int compared   = 0;
  int mismatched = 0;

  int          lat [NCU];
  int          cu_cnt [NCU];
  bit          cu_work [NCU];
  int          m_st [NCU];
  int          new_st [NCU];
  logic [NCU-1:0] prev_rdy, rec_ack, rec_res;
  int          m_jobs = 0, done_seen = 0, max_step = 0, prev_jobs = 0;
  bit          track = 1'b0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Behavioural CUs: ack one cycle after seeing Ready, result lat[n] cycles later
  initial begin
    for (int n = 0; n < NCU; n++) begin cu_work[n] = 1'b0; cu_cnt[n] = 0; lat[n] = 3; end
    forever begin
      @(posedge i_Clock); #1;
      for (int n = 0; n < NCU; n++) begin
        if (!i_Reset) begin
          cu_work[n] = 1'b0; cu_ack[n] = 1'b0; cu_res[n] = 1'b1;
        end else if (!cu_work[n]) begin
          if (o_Indexes_Ready[n]) begin
            cu_ack[n] = 1'b1; cu_res[n] = 1'b0; cu_work[n] = 1'b1; cu_cnt[n] = lat[n];
          end else cu_ack[n] = 1'b0;
        end else begin
          cu_ack[n] = 1'b0;
          if (cu_cnt[n] == 0) begin cu_res[n] = 1'b1; cu_work[n] = 1'b0; end
          else cu_cnt[n] = cu_cnt[n] - 1;
        end
      end
    end
  end

  // Monitor: tracks each slot from observed handshakes and checks every offer
  initial begin
    job_t e;
    int   offers, step;
    bit   lower_free;
    forever begin
      @(negedge i_Clock);
      if (!i_Reset) begin
        for (int m = 0; m < NCU; m++) m_st[m] = 0;
        prev_rdy = 4'b0000; rec_ack = ack_s; rec_res = cu_res; prev_jobs = 0;
      end else begin
        offers = 0;
        for (int m = 0; m < NCU; m++) begin
          new_st[m] = m_st[m];
          if (m_st[m] == 1 && rec_ack[m]) new_st[m] = 2;
          else if (m_st[m] == 2 && rec_res[m]) begin new_st[m] = 0; m_jobs++; end
        end
        for (int m = 0; m < NCU; m++) begin
          if (o_Indexes_Ready[m] && !prev_rdy[m]) begin
            offers++;
            check("offer_from_free_slot", 64'(m_st[m] == 0), 64'd1);
            lower_free = 1'b0;
            for (int k = 0; k < m; k++) if (m_st[k] == 0) lower_free = 1'b1;
            check("offer_lowest_free", 64'(lower_free), 64'd0);
            check("offer_expected", 64'(sb_q.size() > 0), 64'd1);
            if (sb_q.size() > 0) begin
              e = sb_q.pop_front();
              check("offer_row", 64'(o_Row_Index[m*IW +: IW]), 64'(e.r));
              check("offer_col", 64'(o_Column_Index[m*IW +: IW]), 64'(e.c));
            end
            new_st[m] = 1;
          end
        end
        for (int m = 0; m < NCU; m++)
          check("ready_vs_slot", 64'(o_Indexes_Ready[m]), 64'(new_st[m] == 1));
        if (offers > 0) check("one_offer_per_edge", 64'(offers), 64'd1);
        if (track) check("jobs_completed", 64'(o_Jobs_Completed), 64'(m_jobs));
        if (o_Done) done_seen++;
        step = int'(o_Jobs_Completed) - prev_jobs;
        if (step > max_step) max_step = step;
        prev_jobs = int'(o_Jobs_Completed);
        for (int m = 0; m < NCU; m++) m_st[m] = new_st[m];
        prev_rdy = o_Indexes_Ready; rec_ack = ack_s; rec_res = cu_res;
      end
    end
  end

  task automatic start_run(input int mu);
    job_t j;
    @(posedge i_Clock); #1;
    i_mu = MW'(mu); i_Start = 1'b1;
    for (int r = 0; r < mu; r++)
      for (int c = 0; c < mu; c++) begin j.r = IW'(r); j.c = IW'(c); sb_q.push_back(j); end
    @(posedge i_Clock); #1;
    i_Start = 1'b0; m_jobs = 0; track = 1'b1; max_step = 0; done_seen = 0;
  endtask

  task automatic finish_run(input int bound, input int exp_jobs);
    bit seen = 1'b0;
    for (int i = 0; i < bound && !seen; i++) begin
      @(negedge i_Clock);
      if (o_Done) seen = 1'b1;
    end
    check("done_within_bound", 64'(seen), 64'd1);
    repeat (3) @(negedge i_Clock);
    check("final_jobs", 64'(o_Jobs_Completed), 64'(exp_jobs));
    check("done_pulses_once", 64'(done_seen), 64'd1);
    check("all_offers_issued", 64'(sb_q.size()), 64'd0);
    check("idle_not_busy", 64'(o_Busy), 64'd0);
  endtask

  task automatic check_all_zero();
    check("zero_ready", 64'(o_Indexes_Ready), 64'd0);
    check("zero_row", 64'(o_Row_Index), 64'd0);
    check("zero_col", 64'(o_Column_Index), 64'd0);
    check("zero_mu", 64'(o_mu), 64'd0);
    check("zero_busy", 64'(o_Busy), 64'd0);
    check("zero_done", 64'(o_Done), 64'd0);
    check("zero_jobs", 64'(o_Jobs_Completed), 64'd0);
  endtask

  // Directed sequence
  initial begin
    repeat (3) @(posedge i_Clock); #1;
    check_all_zero();
    i_Reset = 1'b1;

    // mu=1: only CU0 gets (0,0); spurious ack on free CU3 ignored
    for (int n = 0; n < NCU; n++) lat[n] = 10;
    start_run(1);
    @(negedge i_Clock);
    check("busy_after_start", 64'(o_Busy), 64'd1);
    check("no_offer_at_t0", 64'(o_Indexes_Ready), 64'd0);
    @(negedge i_Clock);
    check("first_offer_cu0", 64'(o_Indexes_Ready), 64'd1);
    check("o_mu_latched", 64'(o_mu), 64'd1);
    repeat (3) @(posedge i_Clock); #1;
    spur_ack = 4'b1000;
    @(posedge i_Clock); #1;
    spur_ack = 4'b0000;
    finish_run(100, 1);

    // mu=3 with staggered latencies
    lat[0] = 5; lat[1] = 7; lat[2] = 9; lat[3] = 11;
    start_run(3);
    finish_run(500, 9);

    // mu=0: straight through, done after the third edge
    start_run(0);
    @(negedge i_Clock);
    check("mu0_busy_t0", 64'(o_Busy), 64'd1);
    check("mu0_done_t0", 64'(o_Done), 64'd0);
    @(negedge i_Clock);
    check("mu0_done_t1", 64'(o_Done), 64'd0);
    @(negedge i_Clock);
    check("mu0_done_t2", 64'(o_Done), 64'd1);
    check("mu0_busy_t2", 64'(o_Busy), 64'd0);
    @(negedge i_Clock);
    check("mu0_done_t3", 64'(o_Done), 64'd0);
    check("mu0_jobs", 64'(o_Jobs_Completed), 64'd0);
    check("mu0_done_once", 64'(done_seen), 64'd1);

    // mu=2: CU1 and CU2 finish on the same edge
    lat[0] = 4; lat[1] = 6; lat[2] = 5; lat[3] = 8;
    start_run(2);
    finish_run(200, 4);
    check("double_completion_step", 64'(max_step), 64'd2);

    // Mid-run start and mu change ignored, then asynchronous reset
    for (int n = 0; n < NCU; n++) lat[n] = 20;
    start_run(3);
    repeat (6) @(posedge i_Clock); #1;
    i_Start = 1'b1; i_mu = 8'd5;
    @(posedge i_Clock); #1;
    i_Start = 1'b0;
    repeat (3) @(negedge i_Clock);
    check("mid_run_mu_held", 64'(o_mu), 64'd3);
    check("mid_run_busy", 64'(o_Busy), 64'd1);
    @(posedge i_Clock); #3;
    i_Reset = 1'b0; track = 1'b0; sb_q.delete();
    #1;
    check_all_zero();
    @(posedge i_Clock); @(posedge i_Clock); #2;
    i_Reset = 1'b1;
    for (int n = 0; n < NCU; n++) lat[n] = 3;
    start_run(2);
    finish_run(200, 4);

    // Idle: Result_Ready held high plus spurious acks on every free slot
    @(posedge i_Clock); #1;
    spur_ack = 4'b1111;
    @(posedge i_Clock); #1;
    spur_ack = 4'b0000;
    repeat (3) @(negedge i_Clock);
    check("idle_jobs_unchanged", 64'(o_Jobs_Completed), 64'd4);
    check("idle_no_ready", 64'(o_Indexes_Ready), 64'd0);
    check("idle_still_idle", 64'(o_Busy), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: observed running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/block_scheduler.md
# block_scheduler

Top-level job dispatcher for the block-matrix coprocessor. It walks every output block C_ij of a mu×mu block grid in row-major order. Each (i, j) pair goes to a free compute unit (CU) through the per-CU Indexes_Ready / Indexes_Received handshake, and the scheduler tracks each CU until it raises Result_Ready. It sits between the host/config interface and the CU array, and signals completion when every block has been written back.

## Interface
Parameters:
- N_CU, 4: number of CUs served (1..8).
- index_width, 8: width of each block index.
- max_mu_log, 8: width of i_mu.

Ports:
- i_Clock  in  1  system clock, rising edge.
- i_Reset  in  1  asynchronous, active-low reset.
- i_Start  in  1  start-job pulse; sampled only in S_IDLE.
- i_mu  in  max_mu_log  block-grid dimension; latched at start.
- o_mu  out  max_mu_log  latched mu, driven to all CUs, stable for the whole run.
- o_Indexes_Ready  out  N_CU  bit n offers a job to CU n.
- o_Row_Index  out  N_CU*index_width  CU n row index at slice [n*index_width +: index_width].
- o_Column_Index  out  N_CU*index_width  CU n column index, same slicing.
- i_Indexes_Received  in  N_CU  CU acknowledge pulse.
- i_Result_Ready  in  N_CU  CU finished flag; held high by the CU while idle.
- o_Busy  out  1  high in S_RUN and S_DRAIN.
- o_Done  out  1  one-cycle completion pulse.
- o_Jobs_Completed  out  2*max_mu_log  count of results received in the current run.

## Operation
- Top FSM states:
  - S_IDLE: if i_Start, latch mu, compute r_total = mu*mu, clear counters, go to S_RUN.
  - S_RUN: dispatch jobs; go to S_DRAIN when issued == r_total.
  - S_DRAIN: wait until all CUs are FREE, then go to S_DONE.
  - S_DONE: o_Done=1 for one cycle, then go to S_IDLE.
- mu == 0: r_total = 0; S_RUN passes straight to S_DRAIN and then S_DONE, with no offers.
- Per-CU slot state:
  - FREE -> OFFERED: the slot is selected for dispatch. Its index registers load (r_i, r_j) and its o_Indexes_Ready bit goes to 1.
  - OFFERED -> BUSY: i_Indexes_Received[n] is seen high. o_Indexes_Ready[n] clears on that same edge.
  - BUSY -> FREE: i_Result_Ready[n] is seen high. o_Jobs_Completed increments.
- Signals outside the expected slot state are ignored:
  - i_Indexes_Received outside OFFERED.
  - i_Result_Ready outside BUSY. Because the CU holds Result_Ready high while idle, only BUSY slots may count it.
- Dispatch rule:
  - At most one new offer per edge, and only in S_RUN.
  - The target is the lowest-numbered FREE slot.
  - A slot freed on edge t can be offered at edge t+1 at the earliest.
- Index walk:
  - r_j increments after each offer. When r_j == mu-1 it wraps to 0 and r_i increments.
  - issued increments with every offer.
- Completion counting: several slots may complete on the same edge. o_Jobs_Completed adds the number of slots completing on that edge.
- Index outputs hold their value after the handshake until the next offer to that slot.
- i_Start outside S_IDLE is ignored. i_mu changes mid-run have no effect.
- Reset, asynchronous, at any time including mid-run: all slots return to FREE and the FSM to S_IDLE. Every output returns to 0: o_Indexes_Ready, index buses, o_mu, o_Busy, o_Done, o_Jobs_Completed. Internal counters clear.

## Timing
- Start sampled at edge t0 → S_RUN and o_Busy=1 after t0.
- First offer: o_Indexes_Ready[0]=1 with (0,0) after edge t0+1.
- With all CUs free, subsequent offers follow on consecutive edges, one per CU.
- A CU acknowledging on edge ta is seen by the scheduler on edge ta+1, which clears Ready. The CU has already left idle, so no double accept occurs.
- Completion:
  - The last BUSY→FREE transition happens at edge tl.
  - S_DONE is entered at edge tl+1, so o_Done=1 between edges tl+1 and tl+2.
  - o_Busy drops on edge tl+1.
- o_Jobs_Completed holds its final value in S_IDLE until the next start.

## Test plan
- mu=1, N_CU=4, CU model acks 1 cycle after Ready and results 10 cycles later:
  - only CU0 is offered, with (0,0);
  - o_Done pulses once;
  - o_Jobs_Completed=1;
  - no other Ready bit ever rises.
- mu=3, N_CU=4, CU latencies 5/7/9/11 cycles:
  - all 9 jobs are issued in row-major order, with (0,0)..(2,2) each appearing exactly once;
  - each offer goes to the lowest free CU;
  - done arrives with o_Jobs_Completed=9.
- mu=0:
  - o_Done pulses 3 edges after start;
  - no Ready bit asserted;
  - count=0.
- mu=2, CU1 and CU2 raise Result_Ready on the same edge: o_Jobs_Completed increases by 2 on that edge; final count=4.
- i_Start pulsed mid-run is ignored. After reset asserted mid-run:
  - all outputs are 0 immediately;
  - a fresh start with mu=2 completes normally with count=4.
- An idle CU with Result_Ready held high and spurious ack pulses on a FREE slot: neither is counted, and no state change occurs.
